// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: state encoding, byte width
// and the SCK half-period calculation.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int half_cycles(input int clk_hz, input int sck_hz);
        int h;
        h = clk_hz / (2 * sck_hz);
        return (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator for SCK; counter held at zero while Clear
// is high so every phase starts on a fresh count.
module spi_tick_gen #(
    parameter int HALF = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int W = $clog2(HALF) + 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] count;

    assign Tick = !Clear && (count == LAST);

    always_ff @(posedge Clock) begin
        if (!Reset || Clear || Tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/master_spi.sv
// Mode-0 SPI master, one byte per request with optional CS hold.
// Define MASTER_SPI_LSB_FIRST_EN for LSB-first bit order.
module master_spi
    import spi_pkg::*;
#(
    parameter int CLOCK_HZ = 25_000_000,
    parameter int SCK_HZ   = 1_000_000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Request_i,
    input  logic [7:0] Data_i,
    input  logic       Last_i,
    output logic       Ready_o,
    output logic       Done_o,
    output logic [7:0] DataReceived_o,
    output logic       CS_o,
    output logic       SCK_o,
    output logic       MOSI_o,
    input  logic       MISO_i
);

    localparam int HALF = half_cycles(CLOCK_HZ, SCK_HZ);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    state_t     state;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [2:0] nbit;
    logic       last;
    logic       tick;
    logic       clear;
    logic [7:0] tx_next;
    logic [7:0] rx_next;
    logic       first_bit;
    logic       next_bit;

`ifdef MASTER_SPI_LSB_FIRST_EN
    assign first_bit = Data_i[0];
    assign tx_next   = {1'b0, tx[7:1]};
    assign next_bit  = tx[1];
    assign rx_next   = {MISO_i, rx[7:1]};
`else
    assign first_bit = Data_i[7];
    assign tx_next   = {tx[6:0], 1'b0};
    assign next_bit  = tx[6];
    assign rx_next   = {rx[6:0], MISO_i};
`endif

    assign clear = (state == IDLE) || (state == DONE);

    spi_tick_gen #(
        .HALF(HALF)
    ) u_tick (
        .Clock(Clock),
        .Reset(Reset),
        .Clear(clear),
        .Tick (tick)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state          <= IDLE;
            tx             <= '0;
            rx             <= '0;
            nbit           <= '0;
            last           <= 1'b0;
            Ready_o        <= 1'b1;
            Done_o         <= 1'b0;
            DataReceived_o <= '0;
            CS_o           <= 1'b1;
            SCK_o          <= 1'b0;
            MOSI_o         <= 1'b0;
        end else begin
            Done_o <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // DONE accepts too, giving back-to-back bytes
                    if (Request_i) begin
                        tx      <= Data_i;
                        last    <= Last_i;
                        rx      <= '0;
                        nbit    <= '0;
                        CS_o    <= 1'b0;
                        SCK_o   <= 1'b0;
                        MOSI_o  <= first_bit;
                        Ready_o <= 1'b0;
                        state   <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                SETUP, LOW: begin
                    if (tick) begin
                        SCK_o <= 1'b1;
                        rx    <= rx_next;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        SCK_o <= 1'b0;
                        if (nbit == LAST_BIT) begin
                            Done_o         <= 1'b1;
                            DataReceived_o <= rx;
                            Ready_o        <= 1'b1;
                            state          <= DONE;
                            if (last) begin
                                CS_o   <= 1'b1;
                                MOSI_o <= 1'b0;
                            end
                        end else begin
                            tx     <= tx_next;
                            MOSI_o <= next_bit;
                            nbit   <= nbit + 1'b1;
                            state  <= LOW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
